// File: rtl/rn_fc_pkg.sv
// rn_fc_pkg: shared types, default widths and the requantisation helper for the FC sequencer.
//   fc_state_t  : sequencer states
//   ACC_W       : default signed accumulator width
//   OUT_SHIFT   : default arithmetic right shift applied before saturation
//   fc_requant  : (acc + bias) >>> shift, optional ReLU, saturate to int8
package rn_fc_pkg;

    localparam int ACC_W     = 24;
    localparam int OUT_SHIFT = 7;

    typedef enum logic [3:0] {
        IDLE, LOAD, LWAIT, FETCH, DRAIN, WRITE, NEXT, NWAIT, FIN
    } fc_state_t;

    // acc arrives sign-extended to 32 bits; one extra bit keeps the bias add exact
    function automatic logic signed [7:0] fc_requant(
        input logic signed [31:0] acc,
        input logic signed [7:0]  bias,
        input logic               relu,
        input int                 shift = OUT_SHIFT
    );
        logic signed [32:0] s;
        s = $signed({acc[31], acc}) + $signed({{25{bias[7]}}, bias});
        s = s >>> shift;
        if (relu && s < 33'sd0)
            return 8'sh00;
        if (s > 33'sd127)
            return 8'sh7f;
        if (s < -33'sd128)
            return 8'sh80;
        return s[7:0];
    endfunction

endpackage

// File: rtl/rn_fc_acc.sv
// rn_fc_acc: partial-sum accumulator, MAC return counter and int8 requant stage.
//   clk, rst      : clock, synchronous active-low reset
//   clr           : zero accumulator and return count (start of a neuron)
//   en            : accept mac_valid this cycle
//   mac_valid     : partial sum returning from the MAC
//   mac_sum       : signed partial sum
//   bias, relu    : neuron bias and ReLU enable for the requant stage
//   ret_cnt       : number of partial sums accumulated since clr
//   result        : requantised int8 of acc + bias
module rn_fc_acc import rn_fc_pkg::*; #(
    parameter int ACC_W     = rn_fc_pkg::ACC_W,
    parameter int OUT_SHIFT = rn_fc_pkg::OUT_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    mac_valid,
    input  logic signed [ACC_W-1:0] mac_sum,
    input  logic signed [7:0]       bias,
    input  logic                    relu,
    output logic [15:0]             ret_cnt,
    output logic [7:0]              result
);

    logic signed [ACC_W-1:0] acc;

    // accumulator wraps modulo 2^ACC_W by construction
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            ret_cnt <= '0;
        end else if (clr) begin
            acc     <= '0;
            ret_cnt <= '0;
        end else if (en && mac_valid) begin
            acc     <= acc + mac_sum;
            ret_cnt <= ret_cnt + 16'd1;
        end
    end

    assign result = fc_requant(32'(acc), bias, relu, OUT_SHIFT);

endmodule

// File: rtl/rn_fc_ctrl.sv
// rn_fc_ctrl: fully-connected stage sequencer.
//   start/busy/done                 : inference handshake with the top-level FSM
//   cant_neurons, iters_per_neuron,
//   modulo, last, of_offset,
//   struct_ready, bias_FC           : layer/neuron description from the struct
//   next_layer, next_neuron,
//   get_weight                      : struct control pulses/strobe
//   mac_en, mac_mask, in_addr       : kernel chunk issue to the MAC
//   mac_valid, mac_sum              : MAC partial-sum return
//   of_we, of_addr, of_data         : output feature buffer write port
module rn_fc_ctrl import rn_fc_pkg::*; #(
    parameter int INPUTS_MAC = 6,
    parameter int ACC_W      = rn_fc_pkg::ACC_W,
    parameter int OUT_SHIFT  = rn_fc_pkg::OUT_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [7:0]              cant_neurons,
    input  logic [15:0]             iters_per_neuron,
    input  logic [7:0]              modulo,
    input  logic [7:0]              last,
    input  logic [15:0]             of_offset,
    input  logic                    struct_ready,
    input  logic signed [7:0]       bias_FC,
    output logic                    next_layer,
    output logic                    next_neuron,
    output logic                    get_weight,
    output logic                    mac_en,
    output logic [INPUTS_MAC-1:0]   mac_mask,
    output logic [15:0]             in_addr,
    input  logic                    mac_valid,
    input  logic signed [ACC_W-1:0] mac_sum,
    output logic                    of_we,
    output logic [15:0]             of_addr,
    output logic [7:0]              of_data
);

    fc_state_t             state, state_n;
    logic                  waited;
    logic                  clr;
    logic                  last_chunk;
    logic [7:0]            neuron_idx;
    logic [15:0]           chunk_idx;
    logic [15:0]           ret_cnt;
    logic [7:0]            result;
    logic [INPUTS_MAC-1:0] mask_n;

    rn_fc_acc #(.ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (state == FETCH || state == DRAIN),
        .mac_valid (mac_valid),
        .mac_sum   (mac_sum),
        .bias      (bias_FC),
        .relu      (last == 8'd0),
        .ret_cnt   (ret_cnt),
        .result    (result)
    );

    assign last_chunk = chunk_idx == iters_per_neuron - 16'd1;
    // a nonzero modulo trims only the final chunk; modulo >= lane count means all lanes
    assign mask_n     = (last_chunk && modulo != 8'd0 && 32'(modulo) < INPUTS_MAC)
                        ? ~({INPUTS_MAC{1'b1}} << modulo) : '1;
    assign busy       = state != IDLE;
    assign of_addr    = of_we ? of_offset + 16'(neuron_idx) : '0;
    assign of_data    = of_we ? result : '0;

    always_comb begin
        state_n     = state;
        next_layer  = 1'b0;
        next_neuron = 1'b0;
        get_weight  = 1'b0;
        of_we       = 1'b0;
        done        = 1'b0;
        clr         = 1'b0;
        case (state)
            IDLE:  state_n = start ? LOAD : IDLE;
            LOAD: begin
                next_layer = 1'b1;
                state_n    = LWAIT;
            end
            // struct_ready may still reflect the previous request in the first wait cycle
            LWAIT, NWAIT: if (waited && struct_ready) begin
                clr     = 1'b1;
                state_n = (state == LWAIT && cant_neurons == 8'd0)
                          ? (last != 8'd0 ? FIN : LOAD)
                          : (iters_per_neuron == 16'd0 ? WRITE : FETCH);
            end
            FETCH: begin
                get_weight = 1'b1;
                state_n    = last_chunk ? DRAIN : FETCH;
            end
            DRAIN: state_n = ret_cnt == iters_per_neuron ? WRITE : DRAIN;
            WRITE: begin
                of_we   = 1'b1;
                state_n = NEXT;
            end
            NEXT: if (neuron_idx + 8'd1 == cant_neurons) begin
                state_n = last != 8'd0 ? FIN : LOAD;
            end else begin
                next_neuron = 1'b1;
                state_n     = NWAIT;
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            waited     <= 1'b0;
            neuron_idx <= '0;
            chunk_idx  <= '0;
            mac_en     <= 1'b0;
            in_addr    <= '0;
            mac_mask   <= '0;
        end else begin
            state      <= state_n;
            waited     <= state == LWAIT || state == NWAIT;
            mac_en     <= get_weight;
            in_addr    <= get_weight ? 16'(chunk_idx * INPUTS_MAC) : '0;
            mac_mask   <= get_weight ? mask_n : '0;
            chunk_idx  <= clr ? '0 : get_weight ? chunk_idx + 16'd1 : chunk_idx;
            neuron_idx <= (clr && state == LWAIT) ? '0 : state == NEXT ? neuron_idx + 8'd1 : neuron_idx;
        end
    end

endmodule

// File: tb/tb_rn_fc_ctrl.sv
// tb_rn_fc_ctrl: directed bench for rn_fc_ctrl with struct/MAC models and write/chunk scoreboards.
module tb_rn_fc_ctrl;

    localparam int IM = 6;
    localparam int AW = 24;
    localparam int SH = 0;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done;
    logic [7:0]           cant_neurons = '0;
    logic [15:0]          iters_per_neuron = '0;
    logic [7:0]           modulo = '0;
    logic [7:0]           last = '0;
    logic [15:0]          of_offset = '0;
    logic                 struct_ready = 1'b0;
    logic signed [7:0]    bias_FC = '0;
    logic                 next_layer, next_neuron, get_weight, mac_en;
    logic [IM-1:0]        mac_mask;
    logic [15:0]          in_addr;
    logic                 mac_valid = 1'b0;
    logic signed [AW-1:0] mac_sum = '0;
    logic                 of_we;
    logic [15:0]          of_addr;
    logic [7:0]           of_data;

    rn_fc_ctrl #(.INPUTS_MAC(IM), .ACC_W(AW), .OUT_SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cant_neurons(cant_neurons), .iters_per_neuron(iters_per_neuron), .modulo(modulo),
        .last(last), .of_offset(of_offset), .struct_ready(struct_ready), .bias_FC(bias_FC),
        .next_layer(next_layer), .next_neuron(next_neuron), .get_weight(get_weight),
        .mac_en(mac_en), .mac_mask(mac_mask), .in_addr(in_addr),
        .mac_valid(mac_valid), .mac_sum(mac_sum),
        .of_we(of_we), .of_addr(of_addr), .of_data(of_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { int addr; int data; int rets; } wr_t;
    typedef struct packed { int addr; int mask; } ch_t;
    typedef struct packed { int due; int val; } rt_t;

    int c_cant[3], c_iters[3], c_mod[3], c_last[3], c_off[3], c_bias[3];
    int c_nval[3][4];
    int nl;

    wr_t wq[$];
    ch_t cq[$];
    rt_t pend[$];
    wr_t w;
    ch_t ch;

    int cyc = 0, lat = 1, li = -1, ni = 0, rdy_cnt = 0, rets = 0;
    int n_nl = 0, n_gw = 0, n_done = 0;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_q(input int acc, input int bias, input int lst);
        int s;
        s = (acc + bias) >>> SH;
        if (lst == 0 && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic set_layer(input int l, input int cant, input int iters, input int md, input int lst,
                             input int off, input int bias, input int v0, input int v1, input int v2);
        c_cant[l] = cant; c_iters[l] = iters; c_mod[l] = md; c_last[l] = lst;
        c_off[l] = off; c_bias[l] = bias;
        c_nval[l][0] = v0; c_nval[l][1] = v1; c_nval[l][2] = v2; c_nval[l][3] = 0;
    endtask

    // struct model, MAC model and both scoreboards, all evaluated away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (mac_valid) rets++;
        if (next_layer) n_nl++;
        if (get_weight) n_gw++;
        if (done) n_done++;
        if (of_we) begin
            chk("write_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("of_addr", 32'(of_addr), w.addr);
                chk("of_data", {{24{of_data[7]}}, of_data}, w.data);
                chk("returns_before_write", rets, w.rets);
            end
        end
        if (mac_en) begin
            chk("chunk_expected", 32'(cq.size() > 0), 1);
            if (cq.size() > 0) begin
                ch = cq.pop_front();
                chk("in_addr", 32'(in_addr), ch.addr);
                chk("mac_mask", 32'(mac_mask), ch.mask);
            end
            pend.push_back('{cyc + lat, (li >= 0 && ni < 4) ? c_nval[li][ni] : 0});
        end
        if (next_layer || next_neuron || of_we) rets = 0;
        if (next_layer) begin
            li++; ni = 0; rdy_cnt = 3;
        end else if (next_neuron) begin
            ni++; rdy_cnt = 3;
        end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 1) struct_ready = 1'b0;
            if (rdy_cnt == 0 && li >= 0 && li < nl) begin
                cant_neurons     = 8'(c_cant[li]);
                iters_per_neuron = 16'(c_iters[li]);
                modulo           = 8'(c_mod[li]);
                last             = 8'(c_last[li]);
                of_offset        = 16'(c_off[li]);
                bias_FC          = 8'(c_bias[li]);
                struct_ready     = 1'b1;
            end
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mac_valid = 1'b1;
            mac_sum   = 24'(pend[0].val);
            void'(pend.pop_front());
        end else begin
            mac_valid = 1'b0;
            mac_sum   = '0;
        end
    end

    task automatic run_test(input bit restart);
        int exp_gw;
        bit got;
        li = -1; ni = 0; n_nl = 0; n_gw = 0; n_done = 0; exp_gw = 0;
        for (int l = 0; l < nl; l++)
            for (int n = 0; n < c_cant[l]; n++) begin
                wq.push_back('{c_off[l] + n, ref_q(c_iters[l] * c_nval[l][n], c_bias[l], c_last[l]), c_iters[l]});
                for (int c = 0; c < c_iters[l]; c++)
                    cq.push_back('{c * IM, (c == c_iters[l] - 1 && c_mod[l] != 0 && c_mod[l] < IM)
                                           ? (1 << c_mod[l]) - 1 : (1 << IM) - 1});
                exp_gw += c_iters[l];
            end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("next_layer_after_start", 32'(next_layer), 1);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            start = restart && k == 5;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 1);
        repeat (4) @(negedge clk);
        chk("done_pulses", n_done, 1);
        chk("next_layer_pulses", n_nl, nl);
        chk("get_weight_cycles", n_gw, exp_gw);
        chk("writes_left", wq.size(), 0);
        chk("chunks_left", cq.size(), 0);
        chk("busy_after_done", 32'(busy), 0);
    endtask

    initial begin
        bit hit;
        nl = 1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'(|{busy, next_layer, next_neuron, get_weight, mac_en, mac_mask,
                                    in_addr, of_we, of_addr, of_data, done}), 0);
        rst = 1'b1;
        @(negedge clk);

        // two neurons, 3 chunks of 10 each, bias 5
        nl = 1; lat = 1;
        set_layer(0, 2, 3, 0, 1, 100, 5, 10, 10, 0);
        run_test(1'b0);

        // partial final chunk
        set_layer(0, 1, 2, 4, 1, 0, 0, 7, 0, 0);
        run_test(1'b0);

        // ReLU layer followed by saturating final layer, start pulsed while busy
        nl = 2;
        set_layer(0, 2, 2, 0, 0, 20, 0, -100, 500, 0);
        set_layer(1, 3, 4, 3, 1, 40, -3, -50, 250, 3);
        run_test(1'b1);

        // MAC latency longer than fetch gaps
        nl = 1; lat = 3;
        set_layer(0, 1, 6, 0, 1, 7, 1, 4, 0, 0);
        run_test(1'b0);

        // empty layer, then a zero-chunk neuron whose result is bias only
        nl = 2; lat = 1;
        set_layer(0, 0, 2, 0, 0, 50, 0, 0, 0, 0);
        set_layer(1, 1, 0, 0, 1, 3, -7, 0, 0, 0);
        run_test(1'b0);

        // reset mid-FETCH, stale returns land in IDLE, then a clean rerun
        nl = 1; lat = 3;
        set_layer(0, 1, 6, 0, 1, 9, 0, 2, 0, 0);
        li = -1; ni = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clk);
            if (get_weight) hit = 1'b1;
        end
        chk("reached_fetch", 32'(hit), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mid_outputs", 32'(|{busy, next_layer, next_neuron, get_weight, mac_en, mac_mask,
                                        in_addr, of_we, of_addr, of_data, done}), 0);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 0);
        wq.delete();
        cq.delete();
        run_test(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
